glcd_bus_ctrl: RTL
==================

GLCD_BUS_CTRL -- requirements
Module: glcd_bus_ctrl

Interface
REQ-001 Parameters SHALL be: N_CHIP, 2, number of KS0108-type controller chips, one chip-select each, range 1..8.
REQ-002 Parameters SHALL be: SETUP_CYC, 2, clocks from address/data valid to EN rise, >=1.
REQ-003 Parameters SHALL be: EN_CYC, 50, clocks EN stays high, >=1.
REQ-004 Parameters SHALL be: HOLD_CYC, 2, clocks data/cs held after EN fall, >=1.
REQ-005 Parameters SHALL be: RST_CYC, 1000, clocks graphic_lcd_rst held low after reset release, >=1.
REQ-006 Ports SHALL be: clk  in  1  single system clock, all logic on rising edge.
REQ-007 Ports SHALL be: rst_n  in  1  asynchronous active-low reset.
REQ-008 Ports SHALL be: req_valid  in  1  host write request; req_ready  out  1  request accepted when both high.
REQ-009 Ports SHALL be: req_di  in  1  0=command, 1=data; req_data  in  8  byte; req_cs  in  N_CHIP  chip mask, active-high, several bits allowed.
REQ-010 Ports SHALL be: graphic_lcd_d  out  8; graphic_lcd_rw  out  1; graphic_lcd_en  out  1; graphic_lcd_di  out  1; graphic_lcd_rst  out  1  active-low panel reset; graphic_lcd_cs  out  N_CHIP  active-high.
REQ-011 Ports SHALL be: init_done  out  1  high once power-up sequence finished.

Function
REQ-012 States SHALL be RST_HOLD, INIT, IDLE, SETUP, EN_HI, HOLD (plus CLEAR with GLCD_CLEAR_EN); one shared down-counter sized for max(SETUP_CYC,EN_CYC,HOLD_CYC,RST_CYC).
REQ-013 RST_HOLD: graphic_lcd_rst=0 for exactly RST_CYC clocks, then rst=1 and go INIT.
REQ-014 INIT SHALL issue, all cs bits set, di=0: 0x3F (display on) then 0xC0 (start line 0), each as a full SETUP/EN_HI/HOLD cycle.
REQ-015 After INIT (and CLEAR if compiled) init_done SHALL rise and stay high until reset; state IDLE.
REQ-016 req_ready SHALL be high only in IDLE with init_done=1; on req_valid&req_ready, di/data/cs latched, req_ready low from next clock, go SETUP.
REQ-017 Bus cycle: SETUP SETUP_CYC clocks (d,di,cs driven, en=0); EN_HI EN_CYC clocks (en=1); HOLD HOLD_CYC clocks (en=0, d/di/cs held); then cs=0, IDLE, req_ready=1 next clock.
REQ-018 Accepted transfer SHALL take exactly SETUP_CYC+EN_CYC+HOLD_CYC clocks from acceptance edge to IDLE re-entry.
REQ-019 req_cs=0 SHALL be accepted and dropped: no EN pulse, req_ready high again the following clock.
REQ-020 graphic_lcd_rw SHALL be constant 0 (write-only); req_* inputs ignored outside acceptance.
REQ-021 All outputs SHALL be registered; en never high while cs/d/di change.

Reset
REQ-022 rst_n low SHALL asynchronously force: state RST_HOLD, counter=RST_CYC, d=0, rw=0, en=0, di=0, rst=0, cs=0, req_ready=0, init_done=0.
REQ-023 Reset mid-transfer SHALL abort immediately (en=0) and rerun full power-up sequence after release.

Configuration
REQ-024 With GLCD_CLEAR_EN defined, after INIT the block SHALL enter CLEAR: for page p=0..7, all cs set, command 0xB8|p, command 0x40, then 64 data writes of 0x00; then init_done=1.
REQ-025 Without GLCD_CLEAR_EN, CLEAR state and its counters SHALL be absent; INIT goes straight to init_done.

Structure
REQ-026 Package glcd_pkg SHALL hold state enum, command constants (0x3F, 0xC0, 0xB8, 0x40) and page/column counts (8, 64).
REQ-027 Sub-module glcd_bus_timer (loadable down-counter with done flag) is natural; FSM stays in glcd_bus_ctrl.

Verification
REQ-028 Reset release, N_CHIP=2, RST_CYC=10 -> rst low 10 clocks, then 0x3F then 0xC0 with cs=2'b11, di=0, then init_done=1.
REQ-029 After init, req_di=1, req_data=0xA5, req_cs=2'b01 -> d=0xA5, di=1, cs=01, en high exactly 50 clocks, req_ready back after 54 clocks.
REQ-030 req_valid held high with back-to-back requests -> each takes 54 clocks, no en pulse overlaps, data changes only while en=0.
REQ-031 req_cs=0 request -> no en pulse, req_ready low for exactly one clock.
REQ-032 rst_n low during EN_HI -> en=0 and rst=0 same cycle, init_done=0, full init replays.
REQ-033 GLCD_CLEAR_EN defined, N_CHIP=3 -> 8x(2 commands+64 data) writes with cs=3'b111 before init_done rises.

Source files
------------

// File: rtl/glcd_pkg.sv
// Shared types and constants for the KS0108-style graphic LCD bus controller.
// The CLEAR state exists only when GLCD_CLEAR_EN is defined.
package glcd_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        INIT,
        IDLE,
        SETUP,
        EN_HI,
        HOLD
`ifdef GLCD_CLEAR_EN
        , CLEAR
`endif
    } glcd_state_e;

    localparam logic [7:0] CMD_DISPLAY_ON = 8'h3F;
    localparam logic [7:0] CMD_START_LINE = 8'hC0;
    localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
    localparam logic [7:0] CMD_SET_COL    = 8'h40;

    localparam int unsigned N_PAGE = 8;
    localparam int unsigned N_COL  = 64;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/glcd_bus_timer.sv
// Loadable down-counter shared by all timed FSM phases; done_c marks the last clock of a phase.
module glcd_bus_timer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_W'(RST_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done_c = (cnt <= CNT_W'(1));

endmodule

// File: rtl/glcd_bus_ctrl.sv
// Write-only KS0108 bus master: panel reset, init commands, optional clear, then host writes.
// Define GLCD_CLEAR_EN to blank all pages before init_done rises.
module glcd_bus_ctrl
    import glcd_pkg::*;
#(
    parameter int unsigned N_CHIP    = 2,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 50,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned RST_CYC   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_di,
    input  logic [7:0]        req_data,
    input  logic [N_CHIP-1:0] req_cs,
    output logic [7:0]        graphic_lcd_d,
    output logic              graphic_lcd_rw,
    output logic              graphic_lcd_en,
    output logic              graphic_lcd_di,
    output logic              graphic_lcd_rst,
    output logic [N_CHIP-1:0] graphic_lcd_cs,
    output logic              init_done
);

    localparam int unsigned CNT_MAX = max_of(max_of(SETUP_CYC, EN_CYC), max_of(HOLD_CYC, RST_CYC));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    glcd_state_e        state, state_n;
    logic [7:0]         d_n;
    logic               en_n, di_n, rst_n_out, ready_n, init_done_n;
    logic [N_CHIP-1:0]  cs_n;
    logic [1:0]         init_idx, init_idx_n;
    logic               tmr_load, tmr_done_c;
    logic [CNT_W-1:0]   tmr_val;
`ifdef GLCD_CLEAR_EN
    logic [2:0]         clr_page, clr_page_n;
    logic [6:0]         clr_step, clr_step_n;
    logic               clr_done, clr_done_n;
`endif

    glcd_bus_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done_c   (tmr_done_c)
    );

    assign graphic_lcd_rw = 1'b0;

    // State and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RST_HOLD;
            graphic_lcd_d   <= '0;
            graphic_lcd_en  <= 1'b0;
            graphic_lcd_di  <= 1'b0;
            graphic_lcd_rst <= 1'b0;
            graphic_lcd_cs  <= '0;
            req_ready       <= 1'b0;
            init_done       <= 1'b0;
            init_idx        <= '0;
`ifdef GLCD_CLEAR_EN
            clr_page        <= '0;
            clr_step        <= '0;
            clr_done        <= 1'b0;
`endif
        end else begin
            state           <= state_n;
            graphic_lcd_d   <= d_n;
            graphic_lcd_en  <= en_n;
            graphic_lcd_di  <= di_n;
            graphic_lcd_rst <= rst_n_out;
            graphic_lcd_cs  <= cs_n;
            req_ready       <= ready_n;
            init_done       <= init_done_n;
            init_idx        <= init_idx_n;
`ifdef GLCD_CLEAR_EN
            clr_page        <= clr_page_n;
            clr_step        <= clr_step_n;
            clr_done        <= clr_done_n;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        d_n         = graphic_lcd_d;
        en_n        = graphic_lcd_en;
        di_n        = graphic_lcd_di;
        rst_n_out   = graphic_lcd_rst;
        cs_n        = graphic_lcd_cs;
        ready_n     = req_ready;
        init_done_n = init_done;
        init_idx_n  = init_idx;
        tmr_load    = 1'b0;
        tmr_val     = '0;
`ifdef GLCD_CLEAR_EN
        clr_page_n  = clr_page;
        clr_step_n  = clr_step;
        clr_done_n  = clr_done;
`endif
        unique case (state)
            RST_HOLD: begin
                if (tmr_done_c) begin
                    rst_n_out = 1'b1;
                    state_n   = INIT;
                end
            end
            INIT: begin
                if (init_idx == 2'd2) begin
`ifdef GLCD_CLEAR_EN
                    state_n     = CLEAR;
`else
                    init_done_n = 1'b1;
                    ready_n     = 1'b1;
                    state_n     = IDLE;
`endif
                end else begin
                    d_n        = (init_idx == 2'd0) ? CMD_DISPLAY_ON : CMD_START_LINE;
                    di_n       = 1'b0;
                    cs_n       = '1;
                    init_idx_n = init_idx + 2'd1;
                    state_n    = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(SETUP_CYC);
                end
            end
`ifdef GLCD_CLEAR_EN
            CLEAR: begin
                if (clr_done) begin
                    init_done_n = 1'b1;
                    ready_n     = 1'b1;
                    state_n     = IDLE;
                end else begin
                    // Per page: set-page, set-column, then one zero byte per column
                    cs_n = '1;
                    di_n = (clr_step >= 7'd2);
                    if (clr_step == 7'd0) begin
                        d_n = CMD_SET_PAGE | 8'(clr_page);
                    end else if (clr_step == 7'd1) begin
                        d_n = CMD_SET_COL;
                    end else begin
                        d_n = 8'h00;
                    end
                    if (clr_step == 7'(N_COL + 1)) begin
                        clr_step_n = '0;
                        if (clr_page == 3'(N_PAGE - 1)) begin
                            clr_done_n = 1'b1;
                        end else begin
                            clr_page_n = clr_page + 3'd1;
                        end
                    end else begin
                        clr_step_n = clr_step + 7'd1;
                    end
                    state_n  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SETUP_CYC);
                end
            end
`endif
            IDLE: begin
                ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    ready_n = 1'b0;
                    // An empty chip mask is consumed without touching the bus
                    if (|req_cs) begin
                        d_n      = req_data;
                        di_n     = req_di;
                        cs_n     = req_cs;
                        state_n  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(SETUP_CYC);
                    end
                end
            end
            SETUP: begin
                if (tmr_done_c) begin
                    en_n     = 1'b1;
                    state_n  = EN_HI;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(EN_CYC);
                end
            end
            EN_HI: begin
                if (tmr_done_c) begin
                    en_n     = 1'b0;
                    state_n  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC);
                end
            end
            HOLD: begin
                if (tmr_done_c) begin
                    cs_n = '0;
                    if (init_done) begin
                        ready_n = 1'b1;
                        state_n = IDLE;
                    end else begin
`ifdef GLCD_CLEAR_EN
                        state_n = (init_idx == 2'd2) ? CLEAR : INIT;
`else
                        state_n = INIT;
`endif
                    end
                end
            end
            default: state_n = RST_HOLD;
        endcase
    end

endmodule
